// File: rtl/output_port_tx_pkg.sv
// Shared definitions for the output port transmitter: FSM encoding and serial line levels.
package output_port_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy counter separates full from empty.
module sync_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          Reset,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic [DATA_W-1:0]             din_i,
   output logic [DATA_W-1:0]             dout_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge CLK) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/output_port_tx.sv
// Output port: buffers OutputWrite words in a FIFO and sends them as start/data/stop frames.
module output_port_tx
   import output_port_tx_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                          CLK,
   input  logic                          Reset,
   input  logic                          OutputWrite,
   input  logic [DATA_W-1:0]             OutData,
   input  logic                          OverflowClear,
   output logic                          TxSerial,
   output logic                          TxBusy,
   output logic                          FifoFull,
   output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
   output logic                          Overflow
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   tx_state_e          state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               ovf_q, ovf_d;
   logic               pop, drop, baud_done, bit_last;
   logic [DATA_W-1:0]  fifo_dout;
   logic               fifo_full, fifo_empty;

   sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .Reset   (Reset),
      .push_i  (OutputWrite),
      .pop_i   (pop),
      .din_i   (OutData),
      .dout_o  (fifo_dout),
      .count_o (FifoCount),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign bit_last  = (bit_q == BIT_W'(DATA_W - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_done ? '0 : baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               tx_d    = START_BIT;
               busy_d  = 1'b1;
               state_d = START;
            end
         end
         START: if (baud_done) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = '0;
            state_d = DATA;
         end
         DATA: if (baud_done) begin
            if (bit_last) begin
               tx_d    = STOP_BIT;
               state_d = STOP;
            end else begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = bit_q + BIT_W'(1);
            end
         end
         STOP: if (baud_done) begin
            // Chain straight into the next frame when more words are queued.
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               tx_d    = START_BIT;
               state_d = START;
            end else begin
               tx_d    = IDLE_LEVEL;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A dropped push outranks a simultaneous clear.
   assign drop  = OutputWrite && fifo_full && !pop;
   assign ovf_d = drop || (ovf_q && !OverflowClear);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= IDLE_LEVEL;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign TxSerial = tx_q;
   assign TxBusy   = busy_q;
   assign FifoFull = fifo_full;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_output_port_tx.sv
// Self-checking bench for output_port_tx: directed vectors, framed-line checks and a queue-based model.
module tb_output_port_tx;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;
   localparam int FRAME = (DW + 2) * CPB;

   logic          CLK, Reset, ow, clr;
   logic [DW-1:0] od;
   logic          tx, busy, full, ovf;
   logic [2:0]    cnt;

   output_port_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .OutputWrite   (ow),
      .OutData       (od),
      .OverflowClear (clr),
      .TxSerial      (tx),
      .TxBusy        (busy),
      .FifoFull      (full),
      .FifoCount     (cnt),
      .Overflow      (ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;
   int g_busy, g_peak;

   // Reference model: a word queue plus the frame currently on the line.
   logic [DW-1:0] mq[$];
   bit            m_active;
   int            m_cyc;
   logic [DW-1:0] m_cur;
   bit            m_ovf;

   typedef struct {
      bit        ow;
      logic [15:0] d;
      bit        clr;
      bit        e_tx;
      bit        e_busy;
      bit        e_full;
      int        e_cnt;
      bit        e_ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_active = 1'b0;
      m_cyc    = 0;
      m_cur    = '0;
      m_ovf    = 1'b0;
   endtask

   function automatic logic model_tx();
      logic [DW+1:0] f;
      if (!m_active) return 1'b1;
      f = {1'b1, m_cur, 1'b0};
      return f[m_cyc / CPB];
   endfunction

   task automatic model_edge();
      bit pop_now, dropped;
      if (Reset) begin
         model_reset();
         return;
      end
      pop_now = (mq.size() > 0) && (!m_active || m_cyc == FRAME - 1);
      if (m_active) begin
         if (m_cyc == FRAME - 1) m_active = 1'b0;
         else m_cyc++;
      end
      if (pop_now) begin
         m_cur    = mq.pop_front();
         m_active = 1'b1;
         m_cyc    = 0;
      end
      dropped = 1'b0;
      if (ow) begin
         if (mq.size() < DEPTH) mq.push_back(od);
         else begin
            dropped = 1'b1;
            m_ovf   = 1'b1;
         end
      end
      if (clr && !dropped) m_ovf = 1'b0;
   endtask

   task automatic check_model();
      logic [6:0] e, a;
      e = {model_tx(), m_active, (mq.size() == DEPTH), m_ovf, 3'(mq.size())};
      a = {tx, busy, full, ovf, cnt};
      check("model{tx,busy,full,ovf,cnt}", 32'(a), 32'(e));
   endtask

   task automatic step(input bit do_check);
      @(posedge CLK);
      model_edge();
      #1;
      if (busy) g_busy++;
      if (int'(cnt) > g_peak) g_peak = int'(cnt);
      if (do_check) check_model();
   endtask

   task automatic run_until_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step(1'b1);
         if (!m_active && mq.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[9];
      int   exp_bits[18];
      bit   found;

      exp_bits = '{0, 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, 1};
      tbl[0] = '{1'b1, 16'h1230, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
      tbl[1] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
      tbl[2] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0};
      tbl[3] = '{1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0};
      tbl[4] = '{1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0};
      tbl[5] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1};
      tbl[6] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b1};
      tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0};
      tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0};

      Reset = 1'b1; ow = 1'b0; clr = 1'b0; od = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check("reset_tx",    32'(tx),   32'd1);
      check("reset_busy",  32'(busy), 32'd0);
      check("reset_count", 32'(cnt),  32'd0);
      check("reset_full",  32'(full), 32'd0);
      check("reset_ovf",   32'(ovf),  32'd0);
      Reset = 1'b0;
      repeat (3) step(1'b1);

      // Single 0xA5C3 frame, checked against the literal line pattern.
      ow = 1'b1; od = 16'hA5C3;
      step(1'b1);
      ow = 1'b0;
      check("t2_tx_before_start", 32'(tx), 32'd1);
      for (int c = 0; c < FRAME; c++) begin
         step(1'b0);
         check("t2_line", 32'(tx), 32'(exp_bits[c / CPB]));
         check("t2_busy", 32'(busy), 32'd1);
      end
      step(1'b1);
      check("t2_busy_end", 32'(busy), 32'd0);
      check("t2_tx_end",   32'(tx),   32'd1);
      repeat (5) step(1'b1);

      // Five back-to-back pushes while idle.
      g_busy = 0; g_peak = 0;
      for (int i = 0; i < 5; i++) begin
         ow = 1'b1; od = 16'($urandom);
         step(1'b1);
      end
      ow = 1'b0;
      run_until_idle("t3");
      check("t3_peak_count",  32'(g_peak), 32'd4);
      check("t3_ovf",         32'(ovf),    32'd0);
      check("t3_busy_cycles", 32'(g_busy), 32'(5 * FRAME));

      // Six pushes, drop + clear collision, clear pulse, then a push on the chaining pop.
      g_busy = 0; g_peak = 0;
      for (int i = 0; i < 9; i++) begin
         ow = tbl[i].ow; od = tbl[i].d; clr = tbl[i].clr;
         step(1'b1);
         check($sformatf("tbl%0d_tx", i),    32'(tx),   32'(tbl[i].e_tx));
         check($sformatf("tbl%0d_busy", i),  32'(busy), 32'(tbl[i].e_busy));
         check($sformatf("tbl%0d_full", i),  32'(full), 32'(tbl[i].e_full));
         check($sformatf("tbl%0d_count", i), 32'(cnt),  32'(tbl[i].e_cnt));
         check($sformatf("tbl%0d_ovf", i),   32'(ovf),  32'(tbl[i].e_ovf));
      end
      ow = 1'b0; clr = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_active && m_cyc == FRAME - 1 && mq.size() == DEPTH) begin
            found = 1'b1;
            break;
         end
         step(1'b1);
      end
      check("t5_reached_pop_cycle", 32'(found), 32'd1);
      ow = 1'b1; od = 16'h3C3C;
      step(1'b1);
      ow = 1'b0;
      check("t5_count", 32'(cnt), 32'd4);
      check("t5_ovf",   32'(ovf), 32'd0);
      run_until_idle("t5");
      check("t4_t5_busy_cycles", 32'(g_busy), 32'(6 * FRAME));

      // Asynchronous reset mid-frame with overflow set.
      for (int i = 0; i < 6; i++) begin
         ow = 1'b1; od = 16'($urandom);
         step(1'b1);
      end
      ow = 1'b0;
      repeat (30) step(1'b1);
      check("t1_pre_ovf", 32'(ovf), 32'd1);
      #3 Reset = 1'b1;
      #1;
      check("t1_tx",    32'(tx),   32'd1);
      check("t1_busy",  32'(busy), 32'd0);
      check("t1_count", 32'(cnt),  32'd0);
      check("t1_ovf",   32'(ovf),  32'd0);
      model_reset();
      step(1'b1);
      Reset = 1'b0;
      g_busy = 0;
      repeat (100) step(1'b1);
      check("t1_no_resume", 32'(g_busy), 32'd0);

      // Random traffic at several push densities against the model.
      for (int s = 0; s < 4; s++) begin
         int pct;
         pct = (s == 0) ? 2 : (s == 1) ? 5 : (s == 2) ? 25 : 1;
         for (int i = 0; i < 800; i++) begin
            ow  = ($urandom_range(99) < pct);
            od  = 16'($urandom);
            clr = ($urandom_range(99) < 3);
            step(1'b1);
         end
         ow = 1'b0; clr = 1'b0;
         run_until_idle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
